// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a sequential soft-clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     RF_CLK,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*WIDTH-1:0]  rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             drop_nxt;

  always_ff @(posedge RF_CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = SWEEP;
      SWEEP:   if (cnt == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Writes are honoured everywhere except mid-sweep and to a hardwired-zero entry.
    wr_ok    = we && (state != SWEEP) && !((ZERO_REG != 0) && (waddr == '0));
    drop_nxt = we && !wr_ok;
  end

  always_ff @(posedge RF_CLK) begin
    if (reset) begin
      mem      <= '{default: '0};
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_busy <= (state_nxt == SWEEP);
      clr_done <= (state_nxt == DONE);
      wr_drop  <= drop_nxt;
      if (wr_ok) mem[waddr] <= wdata;
      if (state == SWEEP) begin
        mem[cnt] <= '0;
        cnt      <= cnt + 1'b1;
      end else if (state == IDLE && clr_req) begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] ra;
      ra = raddr[i*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata[i*WIDTH +: WIDTH] = '0;
`ifdef RF_BYPASS_EN
      end else if (wr_ok && (ra == waddr)) begin
        rdata[i*WIDTH +: WIDTH] = wdata;
`endif
      end else begin
        rdata[i*WIDTH +: WIDTH] = mem[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build plus a 3-port 16x8 instance.
module tb_regfile_mp;

  logic        RF_CLK = 1'b0;
  logic        reset  = 1'b0;

  logic        we = 1'b0, clr_req = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic        clr_busy, clr_done, wr_drop;

  logic        we6 = 1'b0, clr_req6 = 1'b0;
  logic [2:0]  waddr6 = '0;
  logic [15:0] wdata6 = '0;
  logic [8:0]  raddr6 = '0;
  logic [47:0] rdata6;
  logic        clr_busy6, clr_done6, wr_drop6;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 RF_CLK = ~RF_CLK;

  regfile_mp #(.WIDTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
    .RF_CLK(RF_CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done), .wr_drop(wr_drop)
  );

  regfile_mp #(.WIDTH(16), .AW(3), .NUM_RD(3), .ZERO_REG(1)) u_dut6 (
    .RF_CLK(RF_CLK), .reset(reset), .we(we6), .waddr(waddr6), .wdata(wdata6),
    .raddr(raddr6), .rdata(rdata6), .clr_req(clr_req6), .clr_busy(clr_busy6),
    .clr_done(clr_done6), .wr_drop(wr_drop6)
  );

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_pop(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] v);
    exp_push(tag, v);
    exp_pop(obs);
  endtask

  task automatic step();
    @(posedge RF_CLK);
    #1;
  endtask

  initial begin
    // 1: reset, all entries read zero on both ports
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_done", {31'd0, clr_done}, 32'd0);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0]};
      #1;
      check("rst_rd0", rdata[31:0], 32'd0);
      check("rst_rd1", rdata[63:32], 32'd0);
    end

    // 2: write then read on both ports
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
    #1;
`ifdef RF_BYPASS_EN
    check("wr_cycle_rd0", rdata[31:0], 32'hDEADBEEF);
`else
    check("wr_cycle_rd0", rdata[31:0], 32'd0);
`endif
    step();
    we = 1'b0;
    #1;
    check("wr5_rd0", rdata[31:0], 32'hDEADBEEF);
    check("wr5_rd1", rdata[63:32], 32'hDEADBEEF);

    // 3: write to addr 0 is dropped
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd5, 5'd0};
    step();
    we = 1'b0;
    #1;
    check("z_drop_pulse", {31'd0, wr_drop}, 32'd1);
    check("z_rd0", rdata[31:0], 32'd0);
    check("z_rd1_intact", rdata[63:32], 32'hDEADBEEF);
    step();
    check("z_drop_clear", {31'd0, wr_drop}, 32'd0);

    // 4: fill, sweep, blocked write mid-sweep
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; waddr = a[4:0]; wdata = a;
      step();
    end
    we = 1'b0;
    raddr = {5'd31, 5'd17};
    #1;
    check("fill_rd17", rdata[31:0], 32'd17);
    check("fill_rd31", rdata[63:32], 32'd31);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      check("sw_busy", {31'd0, clr_busy}, 32'd1);
      check("sw_done_lo", {31'd0, clr_done}, 32'd0);
      if (i == 5) begin
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
      end
      step();
      we = 1'b0;
      if (i == 5) check("sw_drop", {31'd0, wr_drop}, 32'd1);
    end
    check("sw_end_busy", {31'd0, clr_busy}, 32'd0);
    check("sw_done_pulse", {31'd0, clr_done}, 32'd1);
    step();
    check("sw_done_once", {31'd0, clr_done}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], 5'd7};
      #1;
      check("sw_rd7", rdata[31:0], 32'd0);
      check("sw_rd_all", rdata[63:32], 32'd0);
    end

    // 5: reset in the middle of a sweep
    we = 1'b1; waddr = 5'd30; wdata = 32'h30;
    step();
    we = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    check("mid_busy", {31'd0, clr_busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_busy", {31'd0, clr_busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      check("mr_no_done", {31'd0, clr_done}, 32'd0);
      step();
    end
    raddr = {5'd30, 5'd3};
    #1;
    check("mr_rd3", rdata[31:0], 32'd0);
    check("mr_rd30", rdata[63:32], 32'd0);

    // 6: 3-port, 16-bit, 8-entry instance
    for (int a = 0; a < 8; a++) begin
      we6 = 1'b1; waddr6 = a[2:0]; wdata6 = 16'hA0 + a[15:0];
      step();
    end
    we6 = 1'b0;
    raddr6 = {3'd7, 3'd1, 3'd1};
    #1;
    check("p6_rd0", {16'd0, rdata6[15:0]}, 32'h00A1);
    check("p6_rd1", {16'd0, rdata6[31:16]}, 32'h00A1);
    check("p6_rd2", {16'd0, rdata6[47:32]}, 32'h00A7);
    raddr6 = {3'd0, 3'd4, 3'd0};
    #1;
    check("p6_rd_zero", {16'd0, rdata6[15:0]}, 32'd0);
    check("p6_rd4", {16'd0, rdata6[31:16]}, 32'h00A4);
    clr_req6 = 1'b1;
    step();
    clr_req6 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("p6_busy", {31'd0, clr_busy6}, 32'd1);
      step();
    end
    check("p6_busy_end", {31'd0, clr_busy6}, 32'd0);
    check("p6_done", {31'd0, clr_done6}, 32'd1);
    #1;
    check("p6_cleared", {16'd0, rdata6[31:16]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
